mem_req_queue: RTL
==================

MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered requests (power of 2, >=2).
REQ-002 SHALL have parameter AW, default 64, request address width.
REQ-003 SHALL have parameter DW, default 64, store data width.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_req_addr / mem_req_data  in  AW / DW  request address and store data from execute.
REQ-007 mem_req_op / mem_req_rd  in  4 / 5  RVMOP_* code and load destination register.
REQ-008 mem_req_valid  in  1; mem_req_retry  out  1: execute-side valid/retry handshake.
REQ-009 dcache_req_addr / dcache_req_data / dcache_req_op / dcache_req_rd  out  AW / DW / 4 / 5  head request to the dcache.
REQ-010 dcache_req_valid  out  1; dcache_req_retry  in  1: dcache-side valid/retry handshake.
REQ-011 dcache_ack_valid  in  1; dcache_ack_rd  in  5: load completion notification.
REQ-012 load_pending  out  32  bit n set = load to xn outstanding (for decode hazard stall).
REQ-013 occupancy  out  $clog2(DEPTH)+1  current entry count.

Function
REQ-014 Transfer on either side SHALL occur only in a cycle with valid=1 and retry=0.
REQ-015 mem_req_retry SHALL equal (occupancy==DEPTH); no enqueue when full, even if a dequeue occurs that cycle.
REQ-016 Storage SHALL be a circular FIFO; head/tail pointers wrap modulo DEPTH; order strictly preserved.
REQ-017 dcache_req_valid SHALL be 1 iff occupancy>0; dcache_req_* SHALL present the head entry, stable while retry=1.
REQ-018 Enqueue and dequeue in the same cycle SHALL leave occupancy unchanged.
REQ-019 Enqueue of a load op with rd!=0 SHALL set load_pending[rd] on the next edge; stores and rd=0 SHALL not.
REQ-020 dcache_ack_valid SHALL clear load_pending[dcache_ack_rd] on the next edge; same-cycle set and clear of one rd SHALL resolve to set.
REQ-021 load_pending[0] SHALL always read 0.
REQ-022 Minimum enqueue-to-dcache_req_valid latency SHALL be 1 cycle (without bypass).

Reset
REQ-023 On reset: occupancy=0, pointers=0, dcache_req_valid=0, mem_req_retry=0, load_pending=0; dcache_req_addr/data/op/rd=0.
REQ-024 Reset asserted mid-operation SHALL discard all entries and pending bits in that cycle; no request issues on the following cycle.

Configuration
REQ-025 With MEM_REQ_QUEUE_BYPASS_EN defined: when empty and mem_req_valid=1, the incoming request SHALL drive dcache_req_* combinationally; if dcache_req_retry=0 it is consumed that cycle without occupying an entry (latency 0); else it is enqueued.
REQ-026 Without MEM_REQ_QUEUE_BYPASS_EN: no combinational path from mem_req_* to dcache_req_*; REQ-022 holds.

Structure
REQ-027 RVMOP_* encodings and an is_load(op) function SHALL live in the shared core package, not in this module.
REQ-028 The FIFO storage/pointers SHALL be one sub-module, mem_req_fifo; the scoreboard stays in mem_req_queue.

Verification
REQ-029 DEPTH=4, dcache_req_retry=1, enqueue 4 loads rd=1..4 -> mem_req_retry=1 after 4th, occupancy=4, load_pending=0x1E.
REQ-030 Then hold mem_req_valid=1 and drop dcache_req_retry for 1 cycle -> rd=1 issued, 5th not accepted that cycle, accepted next cycle, occupancy returns to 4.
REQ-031 Store addr=0x1000 data=0xDEADBEEF then load rd=5 -> issued in order, load_pending[5]=1 only after load enqueue, store sets no bit.
REQ-032 Load rd=7 enqueued same cycle as dcache_ack_valid rd=7 -> load_pending[7]=1.
REQ-033 Pointer wrap: 10 back-to-back requests with dcache_req_retry=0 -> all issued in order, occupancy never exceeds 1.
REQ-034 Reset asserted with occupancy=3 -> next cycle dcache_req_valid=0, occupancy=0, load_pending=0; with BYPASS_EN, empty queue + retry=0 -> request on dcache_req_* same cycle.

Source files
------------

// File: rtl/mem_req_queue_pkg.sv
// Shared core package: memory-op encodings, register-file sizing and the is_load() classifier
// used by the memory request queue.
package mem_req_queue_pkg;

    localparam int OP_W      = 4;
    localparam int RD_W      = 5;
    localparam int NUM_XREGS = 32;

    localparam logic [OP_W-1:0] RVMOP_LB  = 4'h0;
    localparam logic [OP_W-1:0] RVMOP_LH  = 4'h1;
    localparam logic [OP_W-1:0] RVMOP_LW  = 4'h2;
    localparam logic [OP_W-1:0] RVMOP_LD  = 4'h3;
    localparam logic [OP_W-1:0] RVMOP_LBU = 4'h4;
    localparam logic [OP_W-1:0] RVMOP_LHU = 4'h5;
    localparam logic [OP_W-1:0] RVMOP_LWU = 4'h6;
    localparam logic [OP_W-1:0] RVMOP_SB  = 4'h8;
    localparam logic [OP_W-1:0] RVMOP_SH  = 4'h9;
    localparam logic [OP_W-1:0] RVMOP_SW  = 4'hA;
    localparam logic [OP_W-1:0] RVMOP_SD  = 4'hB;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        case (op)
            RVMOP_LB, RVMOP_LH, RVMOP_LW, RVMOP_LD,
            RVMOP_LBU, RVMOP_LHU, RVMOP_LWU: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Circular FIFO holding buffered memory requests; head/tail wrap modulo DEPTH (power of 2).
module mem_req_fifo
    import mem_req_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int DW    = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [AW-1:0]   push_addr,
    input  logic [DW-1:0]   push_data,
    input  logic [OP_W-1:0] push_op,
    input  logic [RD_W-1:0] push_rd,
    output logic [AW-1:0]   head_addr,
    output logic [DW-1:0]   head_data,
    output logic [OP_W-1:0] head_op,
    output logic [RD_W-1:0] head_rd,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic            full
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [AW-1:0]   addr_mem_r [DEPTH];
    logic [DW-1:0]   data_mem_r [DEPTH];
    logic [OP_W-1:0] op_mem_r   [DEPTH];
    logic [RD_W-1:0] rd_mem_r   [DEPTH];

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign count     = count_r;

    assign head_addr = addr_mem_r[head_r];
    assign head_data = data_mem_r[head_r];
    assign head_op   = op_mem_r[head_r];
    assign head_rd   = rd_mem_r[head_r];

    // Entry storage written at the tail; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            addr_mem_r[tail_r] <= push_addr;
            data_mem_r[tail_r] <= push_data;
            op_mem_r[tail_r]   <= push_op;
            rd_mem_r[tail_r]   <= push_rd;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_queue.sv
// Memory request queue between execute and dcache with a load-destination scoreboard.
// Optional same-cycle bypass when empty: define MEM_REQ_QUEUE_BYPASS_EN.
module mem_req_queue
    import mem_req_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AW-1:0]          mem_req_addr,
    input  logic [DW-1:0]          mem_req_data,
    input  logic [OP_W-1:0]        mem_req_op,
    input  logic [RD_W-1:0]        mem_req_rd,
    input  logic                   mem_req_valid,
    output logic                   mem_req_retry,
    output logic [AW-1:0]          dcache_req_addr,
    output logic [DW-1:0]          dcache_req_data,
    output logic [OP_W-1:0]        dcache_req_op,
    output logic [RD_W-1:0]        dcache_req_rd,
    output logic                   dcache_req_valid,
    input  logic                   dcache_req_retry,
    input  logic                   dcache_ack_valid,
    input  logic [RD_W-1:0]        dcache_ack_rd,
    output logic [NUM_XREGS-1:0]   load_pending,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam logic [NUM_XREGS-1:0] X0_MASK = 32'hFFFF_FFFE;

    logic [AW-1:0]          head_addr_s;
    logic [DW-1:0]          head_data_s;
    logic [OP_W-1:0]        head_op_s;
    logic [RD_W-1:0]        head_rd_s;
    logic                   empty_s;
    logic                   full_s;
    logic                   accept_s;
    logic                   bypass_s;
    logic                   push_s;
    logic                   pop_s;
    logic [NUM_XREGS-1:0]   set_mask_s;
    logic [NUM_XREGS-1:0]   clr_mask_s;
    logic [NUM_XREGS-1:0]   load_pending_r;

    assign mem_req_retry = full_s;
    assign accept_s      = mem_req_valid & ~full_s;
    assign pop_s         = ~empty_s & ~dcache_req_retry;

`ifdef MEM_REQ_QUEUE_BYPASS_EN
    assign bypass_s = empty_s & mem_req_valid & ~dcache_req_retry;
`else
    assign bypass_s = 1'b0;
`endif
    // A bypassed request is consumed directly by the dcache and never occupies an entry
    assign push_s = accept_s & ~bypass_s;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_addr (mem_req_addr),
        .push_data (mem_req_data),
        .push_op   (mem_req_op),
        .push_rd   (mem_req_rd),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .head_op   (head_op_s),
        .head_rd   (head_rd_s),
        .count     (occupancy),
        .empty     (empty_s),
        .full      (full_s)
    );

    // dcache request mux: head entry when occupied, zeros when idle
    always_comb begin
        dcache_req_valid = 1'b0;
        dcache_req_addr  = {AW{1'b0}};
        dcache_req_data  = {DW{1'b0}};
        dcache_req_op    = {OP_W{1'b0}};
        dcache_req_rd    = {RD_W{1'b0}};
        if (!empty_s) begin
            dcache_req_valid = 1'b1;
            dcache_req_addr  = head_addr_s;
            dcache_req_data  = head_data_s;
            dcache_req_op    = head_op_s;
            dcache_req_rd    = head_rd_s;
        end
`ifdef MEM_REQ_QUEUE_BYPASS_EN
        else if (mem_req_valid) begin
            dcache_req_valid = 1'b1;
            dcache_req_addr  = mem_req_addr;
            dcache_req_data  = mem_req_data;
            dcache_req_op    = mem_req_op;
            dcache_req_rd    = mem_req_rd;
        end
`endif
        else begin
            dcache_req_valid = 1'b0;
        end
    end

    // Scoreboard set/clear masks for this cycle's accepted load and dcache ack
    always_comb begin
        set_mask_s = {NUM_XREGS{1'b0}};
        clr_mask_s = {NUM_XREGS{1'b0}};
        if (accept_s && is_load(mem_req_op)) begin
            set_mask_s[mem_req_rd] = 1'b1;
        end else begin
            set_mask_s = {NUM_XREGS{1'b0}};
        end
        if (dcache_ack_valid) begin
            clr_mask_s[dcache_ack_rd] = 1'b1;
        end else begin
            clr_mask_s = {NUM_XREGS{1'b0}};
        end
    end

    // Pending-load scoreboard; set wins over clear, x0 never pending
    always_ff @(posedge clk) begin
        if (reset) begin
            load_pending_r <= {NUM_XREGS{1'b0}};
        end else begin
            load_pending_r <= ((load_pending_r & ~clr_mask_s) | set_mask_s) & X0_MASK;
        end
    end

    assign load_pending = load_pending_r;

endmodule
